alu_seq: RTL and testbench
==========================

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter WIDTH, default 8: data path width in bits; legal values are 4 to 32.
REQ-002 Parameter SHW, default $clog2(WIDTH)+1: width of the shift amount.
REQ-003 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 Port in_valid, input, 1 bit: an operation request is present.
REQ-006 Port in_ready, output, 1 bit: the block can accept a request; transfer occurs when in_valid && in_ready at a rising edge.
REQ-007 Port operation, input, 4 bits: operation select, encoded per REQ-016.
REQ-008 Ports ina and inb, input, WIDTH bits each: operands.
REQ-009 Port shamt, input, SHW bits: shift/rotate amount.
REQ-010 Port out_valid, output, 1 bit: one-cycle pulse marking that a new result is present.
REQ-011 Port out, output, WIDTH bits: primary result (product low half, or quotient).
REQ-012 Port out_hi, output, WIDTH bits: product high half or remainder; 0 for all other operations.
REQ-013 Ports cr, ov, ng, zr, output, 1 bit each: carry/borrow, signed overflow, negative, zero.
REQ-014 Port dz, output, 1 bit: divide by zero.

Function
REQ-015 All outputs are registered; out, out_hi and the flags hold their values until the next out_valid.
REQ-016 Operation encoding:
- 0000 ADD; 0001 SUB; 0010 AND; 0011 OR; 0100 NOT ina; 0101 SLT (signed);
- 0110 SLL; 0111 ROR; 1000 MULU; 1001 DIVU;
- all other codes are illegal: out=0, out_hi=0, zr=1, all other flags 0.
REQ-017 FSM states and transitions:
- IDLE: in_ready=1.
- MUL and DIV: in_ready=0.
- IDLE->MUL on acceptance of MULU; IDLE->DIV on acceptance of DIVU when inb!=0.
- MUL/DIV->IDLE after WIDTH iteration cycles.
REQ-018 Single-cycle operations (everything except MULU/DIVU, plus DIVU with inb=0): out_valid asserts in the cycle after acceptance, and the FSM stays in IDLE, so back-to-back requests are accepted every cycle.
REQ-019 MULU/DIVU: exactly WIDTH iteration cycles; out_valid asserts WIDTH+1 cycles after acceptance, with in_ready=1 in that same cycle.
REQ-020 ADD/SUB flags:
- cr: ADD carry-out; SUB borrow (ina<inb unsigned).
- ov: signed overflow.
- ng = out[WIDTH-1]; zr = (out==0).
REQ-021 Logic, SLT and shift operations: ng and zr from out; cr=0; ov=0. SLT gives out=1 when ina<inb signed, else 0.
REQ-022 SLL shifts ina left by shamt; shamt>=WIDTH gives out=0.
REQ-023 ROR rotates ina right by shamt mod WIDTH.
REQ-024 MULU: {out_hi,out} = ina*inb unsigned; cr=ov=(out_hi!=0); ng = out_hi[WIDTH-1]; zr = (full product == 0).
REQ-025 DIVU: restoring division; out = quotient, out_hi = remainder; dz=0; ng=0; zr = (quotient==0).
REQ-026 DIVU with inb=0: dz=1, out = all ones, out_hi = ina, cr=ov=ng=zr=0, latency 1.
REQ-027 dz is 0 for every result except DIVU by zero.
REQ-028 Operands are captured at acceptance; changes to the inputs while busy have no effect.
REQ-029 in_valid asserted while in_ready=0 is ignored and not queued.

Reset
REQ-030 rst at a rising edge forces state IDLE, in_ready=1, out_valid=0, out=0, out_hi=0, and all flags and dz to 0.
REQ-031 rst during MUL/DIV aborts the operation: no out_valid is produced for it, and a request is accepted on the first edge after rst deasserts.
REQ-032 rst has priority over a simultaneous in_valid.

Structure
REQ-033 Package alu_pkg holds the operation code localparams and the FSM state typedef (IDLE, MUL, DIV).
REQ-034 The iterative shift-add multiplier and restoring divider are one sub-module, alu_muldiv_iter, parametrised by WIDTH, with a start/done interface; it is instantiated once.

Verification (WIDTH=8)
REQ-035 ADD 0x81+0x99 -> out=0x1A, cr=1, ov=1, ng=0, zr=0, out_valid one cycle after accept.
REQ-036 SUB 0x81-0x99 -> out=0xE8, cr=1, ov=0, ng=1; then SUB 0x99-0x81 on the next cycle -> out=0x18, cr=0; two consecutive out_valid pulses.
REQ-037 MULU 0xFF*0xFF -> out=0x01, out_hi=0xFE, cr=ov=1; in_ready=0 for 8 cycles; out_valid exactly 9 cycles after accept.
REQ-038 DIVU 200/7 -> out=28, out_hi=4, dz=0 at 9 cycles; DIVU 0x55/0 -> dz=1, out=0xFF, out_hi=0x55 at 1 cycle.
REQ-039 ROR 0x81 with shamt=1 -> out=0xC0; SLL 0x0F with shamt=9 -> out=0x00, zr=1; SLT 5 vs 0xF6 -> out=0.
REQ-040 rst asserted 4 cycles into MULU -> no out_valid, all outputs 0, in_ready=1, and a following ADD completes normally.

Source files
------------

// File: rtl/alu_pkg.sv
// Operation codes and FSM state type shared by the sequential ALU.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_NOT  = 4'b0100;
  localparam logic [3:0] OP_SLT  = 4'b0101;
  localparam logic [3:0] OP_SLL  = 4'b0110;
  localparam logic [3:0] OP_ROR  = 4'b0111;
  localparam logic [3:0] OP_MULU = 4'b1000;
  localparam logic [3:0] OP_DIVU = 4'b1001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } state_t;

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative shift-add multiplier / restoring divider, one bit per cycle.
// hi/lo hold the partial product or remainder/quotient; res_* expose next-state values.
module alu_muldiv_iter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] res_lo,
  output logic [WIDTH-1:0] res_hi
);
  localparam int CW = $clog2(WIDTH) + 1;

  logic             busy_q;
  logic             div_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH:0]   shifted, trial, sum;

  always_comb begin
    hi_d    = hi_q;
    lo_d    = lo_q;
    shifted = {hi_q, lo_q[WIDTH-1]};
    trial   = shifted - {1'b0, b_q};
    sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    if (div_q) begin
      // Bit WIDTH of the trial difference is set exactly when it went negative
      if (!trial[WIDTH]) begin
        hi_d = trial[WIDTH-1:0];
        lo_d = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        hi_d = shifted[WIDTH-1:0];
        lo_d = {lo_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      {hi_d, lo_d} = {sum, lo_q[WIDTH-1:1]};
    end
  end

  assign done   = busy_q && (cnt_q == CW'(WIDTH - 1));
  assign res_lo = lo_d;
  assign res_hi = hi_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      div_q  <= 1'b0;
      cnt_q  <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      b_q    <= '0;
    end else if (start) begin
      busy_q <= 1'b1;
      div_q  <= is_div;
      cnt_q  <= '0;
      hi_q   <= '0;
      lo_q   <= a;
      b_q    <= b;
    end else if (busy_q) begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      cnt_q <= cnt_q + 1'b1;
      if (done) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle arithmetic/logic/shift ops, iterative MULU/DIVU.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       operation,
  input  logic [WIDTH-1:0] ina,
  input  logic [WIDTH-1:0] inb,
  input  logic [SHW-1:0]   shamt,
  output logic             out_valid,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_hi,
  output logic             cr,
  output logic             ov,
  output logic             ng,
  output logic             zr,
  output logic             dz
);
  state_t           state_q;
  logic             in_ready_q, out_valid_q;
  logic [WIDTH-1:0] out_q, out_hi_q;
  logic             cr_q, ov_q, ng_q, zr_q, dz_q;

  logic [WIDTH:0]   add_w, sub_w;
  logic [31:0]      rot_amt;
  logic [WIDTH-1:0] sc_out, sc_hi;
  logic             sc_cr, sc_ov, sc_ng, sc_zr, sc_dz;
  logic             is_iter, md_start, md_done;
  logic [WIDTH-1:0] md_lo, md_hi;

  assign add_w   = {1'b0, ina} + {1'b0, inb};
  assign sub_w   = {1'b0, ina} - {1'b0, inb};
  assign rot_amt = 32'(shamt) % 32'(WIDTH);

  always_comb begin
    sc_out = '0;
    sc_hi  = '0;
    sc_cr  = 1'b0;
    sc_ov  = 1'b0;
    sc_dz  = 1'b0;
    case (operation)
      OP_ADD: begin
        sc_out = add_w[WIDTH-1:0];
        sc_cr  = add_w[WIDTH];
        sc_ov  = (ina[WIDTH-1] == inb[WIDTH-1]) && (add_w[WIDTH-1] != ina[WIDTH-1]);
      end
      OP_SUB: begin
        sc_out = sub_w[WIDTH-1:0];
        sc_cr  = sub_w[WIDTH];
        sc_ov  = (ina[WIDTH-1] != inb[WIDTH-1]) && (sub_w[WIDTH-1] != ina[WIDTH-1]);
      end
      OP_AND:  sc_out = ina & inb;
      OP_OR:   sc_out = ina | inb;
      OP_NOT:  sc_out = ~ina;
      OP_SLT:  sc_out = {{(WIDTH-1){1'b0}}, ($signed(ina) < $signed(inb))};
      OP_SLL:  sc_out = (shamt >= SHW'(WIDTH)) ? '0 : (ina << shamt);
      OP_ROR:  sc_out = (ina >> rot_amt) | (ina << (32'(WIDTH) - rot_amt));
      OP_DIVU: begin
        // Only reaches the output path when the divisor is zero
        sc_out = '1;
        sc_hi  = ina;
        sc_dz  = 1'b1;
      end
      default: ;
    endcase
    sc_ng = sc_out[WIDTH-1] & ~sc_dz;
    sc_zr = (sc_out == '0) & ~sc_dz;
  end

  assign is_iter  = (operation == OP_MULU) || ((operation == OP_DIVU) && (inb != '0));
  assign md_start = (state_q == IDLE) && in_valid && is_iter;

  alu_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
    .clk    (clk),
    .rst    (rst),
    .start  (md_start),
    .is_div (operation == OP_DIVU),
    .a      (ina),
    .b      (inb),
    .done   (md_done),
    .res_lo (md_lo),
    .res_hi (md_hi)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      out_hi_q    <= '0;
      cr_q        <= 1'b0;
      ov_q        <= 1'b0;
      ng_q        <= 1'b0;
      zr_q        <= 1'b0;
      dz_q        <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      case (state_q)
        IDLE: if (in_valid) begin
          if (is_iter) begin
            state_q    <= (operation == OP_MULU) ? MUL : DIV;
            in_ready_q <= 1'b0;
          end else begin
            out_valid_q <= 1'b1;
            out_q       <= sc_out;
            out_hi_q    <= sc_hi;
            cr_q        <= sc_cr;
            ov_q        <= sc_ov;
            ng_q        <= sc_ng;
            zr_q        <= sc_zr;
            dz_q        <= sc_dz;
          end
        end
        MUL, DIV: if (md_done) begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b1;
          out_q       <= md_lo;
          out_hi_q    <= md_hi;
          dz_q        <= 1'b0;
          if (state_q == MUL) begin
            cr_q <= |md_hi;
            ov_q <= |md_hi;
            ng_q <= md_hi[WIDTH-1];
            zr_q <= ~|{md_hi, md_lo};
          end else begin
            cr_q <= 1'b0;
            ov_q <= 1'b0;
            ng_q <= 1'b0;
            zr_q <= ~|md_lo;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign out_hi    = out_hi_q;
  assign cr        = cr_q;
  assign ov        = ov_q;
  assign ng        = ng_q;
  assign zr        = zr_q;
  assign dz        = dz_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq at WIDTH=8: directed cases plus random ops vs an arithmetic model.
module tb_alu_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] operation;
  logic [7:0] ina, inb;
  logic [3:0] shamt;
  logic       out_valid;
  logic [7:0] out, out_hi;
  logic       cr, ov, ng, zr, dz;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [7:0] out;
    logic [7:0] hi;
    logic [4:0] flg;
    int         lat;
  } exp_t;

  alu_seq #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .operation (operation),
    .ina       (ina),
    .inb       (inb),
    .shamt     (shamt),
    .out_valid (out_valid),
    .out       (out),
    .out_hi    (out_hi),
    .cr        (cr),
    .ov        (ov),
    .ng        (ng),
    .zr        (zr),
    .dz        (dz)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic int sx(input int v);
    return (v >= 128) ? v - 256 : v;
  endfunction

  // Reference model in plain integer arithmetic; flg = {cr, ov, ng, zr, dz}
  function automatic exp_t model(input int op, input int a, input int b, input int sh);
    exp_t e;
    int   r, s, hi, cr_b, ov_b, dz_b, lat, p, k;
    bit   own_nz;
    r = 0; hi = 0; cr_b = 0; ov_b = 0; dz_b = 0; lat = 1; own_nz = 0;
    case (op)
      0: begin s = a + b; r = s % 256; cr_b = (s > 255); s = sx(a) + sx(b); ov_b = (s > 127 || s < -128); end
      1: begin r = (a - b + 256) % 256; cr_b = (a < b); s = sx(a) - sx(b); ov_b = (s > 127 || s < -128); end
      2: r = a & b;
      3: r = a | b;
      4: r = 255 - a;
      5: r = (sx(a) < sx(b)) ? 1 : 0;
      6: r = (sh >= 8) ? 0 : ((a << sh) % 256);
      7: begin k = sh % 8; r = ((a >> k) | (a << (8 - k))) % 256; end
      8: begin
        p = a * b; r = p % 256; hi = p / 256; cr_b = (hi != 0); ov_b = cr_b; lat = 9;
        own_nz = 1;
        e.flg = {cr_b[0], ov_b[0], (hi >= 128), (p == 0), 1'b0};
      end
      9: begin
        if (b == 0) begin
          r = 255; hi = a; dz_b = 1; own_nz = 1;
          e.flg = 5'b00001;
        end else begin
          r = a / b; hi = a % b; lat = 9; own_nz = 1;
          e.flg = {3'b000, (r == 0), 1'b0};
        end
      end
      default: r = 0;
    endcase
    e.out = r[7:0];
    e.hi  = hi[7:0];
    e.lat = lat;
    if (!own_nz) e.flg = {cr_b[0], ov_b[0], (r >= 128), (r == 0), dz_b[0]};
    return e;
  endfunction

  // Call #1 after a rising edge; returns #1 after the edge where out_valid is seen
  task automatic run_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [3:0] sh);
    exp_t e;
    int   lat;
    e = model(int'(op), int'(a), int'(b), int'(sh));
    in_valid = 1'b1; operation = op; ina = a; inb = b; shamt = sh;
    check("ready_at_issue", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    operation = 4'($urandom); ina = 8'($urandom); inb = 8'($urandom); shamt = 4'($urandom);
    lat = 1;
    while (!out_valid && lat < 40) begin
      check("busy_not_ready", {31'd0, in_ready}, 32'd0);
      in_valid = 1'($urandom);
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat++;
    end
    check($sformatf("lat_op%0d", op), lat, e.lat);
    check($sformatf("out_op%0d", op), {24'd0, out}, {24'd0, e.out});
    check($sformatf("hi_op%0d", op), {24'd0, out_hi}, {24'd0, e.hi});
    check($sformatf("flags_op%0d", op), {27'd0, cr, ov, ng, zr, dz}, {27'd0, e.flg});
    check("ready_at_result", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    exp_t e;
    logic [3:0] rop;
    int quiet;
    rst = 1'b1; in_valid = 1'b1; operation = 4'd0; ina = 8'h11; inb = 8'h22; shamt = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; in_valid = 1'b0;
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_ready", {31'd0, in_ready}, 32'd1);
    check("rst_outs", {8'd0, out, out_hi, 3'd0, cr, ov, ng, zr, dz}, 32'd0);

    run_op(4'd0, 8'h81, 8'h99, 4'd0);
    check("add_out", {24'd0, out}, 32'h1A);
    check("add_flags", {27'd0, cr, ov, ng, zr, dz}, 32'b11000);

    // Back-to-back SUBs accepted on consecutive edges
    in_valid = 1'b1; operation = 4'd1; ina = 8'h81; inb = 8'h99;
    @(posedge clk); #1;
    ina = 8'h99; inb = 8'h81;
    check("sub1_valid", {31'd0, out_valid}, 32'd1);
    check("sub1_out", {24'd0, out}, 32'hE8);
    check("sub1_flags", {27'd0, cr, ov, ng, zr, dz}, 32'b10100);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("sub2_valid", {31'd0, out_valid}, 32'd1);
    check("sub2_out", {24'd0, out}, 32'h18);
    check("sub2_cr", {31'd0, cr}, 32'd0);
    @(posedge clk); #1;
    check("pulse_low", {31'd0, out_valid}, 32'd0);
    check("hold_out", {24'd0, out}, 32'h18);

    run_op(4'd8, 8'hFF, 8'hFF, 4'd0);
    check("mul_res", {16'd0, out_hi, out}, 32'hFE01);
    run_op(4'd9, 8'd200, 8'd7, 4'd0);
    check("div_res", {16'd0, out_hi, out}, {16'd0, 8'd4, 8'd28});
    run_op(4'd9, 8'h55, 8'h00, 4'd0);
    check("divz_res", {15'd0, dz, out_hi, out}, {15'd0, 1'b1, 8'h55, 8'hFF});
    run_op(4'd7, 8'h81, 8'h00, 4'd1);
    check("ror_out", {24'd0, out}, 32'hC0);
    run_op(4'd6, 8'h0F, 8'h00, 4'd9);
    check("sll_big", {23'd0, zr, out}, {23'd0, 1'b1, 8'h00});
    run_op(4'd5, 8'd5, 8'hF6, 4'd0);
    check("slt_out", {24'd0, out}, 32'd0);
    run_op(4'd13, 8'h12, 8'h34, 4'd0);

    // Reset in the middle of a multiply aborts it
    in_valid = 1'b1; operation = 4'd8; ina = 8'hA5; inb = 8'h3C;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_valid", {31'd0, out_valid}, 32'd0);
    check("abort_ready", {31'd0, in_ready}, 32'd1);
    check("abort_outs", {8'd0, out, out_hi, 3'd0, cr, ov, ng, zr, dz}, 32'd0);
    run_op(4'd0, 8'h10, 8'h20, 4'd0);
    check("post_abort_add", {24'd0, out}, 32'h30);
    quiet = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (out_valid) quiet++;
    end
    check("no_stray_valid", quiet, 0);

    for (int i = 0; i < 150; i++) begin
      rop = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      run_op(rop, 8'($urandom), ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom), 4'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
